control_sequencer: RTL
======================

Name: control_sequencer

Overview:
Hardwired Moore control unit that sequences DataPath through fetch and execute for the Mini-CPU instruction subset. It replaces the hand-driven per-instruction testbench sequences with one FSM. Outputs connect one-to-one to the DataPath control inputs. Inputs are IR and CON_FF from DataPath and an external Stop.

Parameters:
OPW, 5, opcode width, IR[31:27]
ALUW, 4, alu_op width

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
IR  in  32  instruction register contents from DataPath
CON_FF  in  1  branch condition flip-flop from DataPath
Stop  in  1  halt request; honoured at the instruction boundary
drv_out  out  10  one-hot bus driver: 0 PCout, 1 Zlowout, 2 Zhighout, 3 MDRout, 4 HIout, 5 LOout, 6 InPortout, 7 Csignout, 8 Rout, 9 BAout
ld_in  out  12  register loads: 0 PCin, 1 MARin, 2 MDRin, 3 IRin, 4 Yin, 5 Zlowin, 6 Zhighin, 7 HIin, 8 LOin, 9 OutPortin, 10 CONin, 11 Rin
gr_sel  out  3  {Gra, Grb, Grc}, at most one bit high
IncPC  out  1  ALU computes PC+1
Read  out  1  memory read
Write  out  1  memory write
MD_read  out  1  MDR mux selects memory data
alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR
Run  out  1  high while executing

Behaviour:
- One state per clock. Outputs are decoded from the registered state and IR only. No output depends combinationally on Stop. All outputs stay stable for the whole cycle.
- drv_out is never multi-hot. All outputs not listed for a state are 0. alu_op is 0000 unless stated.
- While clear is high: state=RESET, all outputs 0, Run=0. On the first edge after clear falls, go to F0.
- Fetch sequence:
  - F0: PCout, MARin, IncPC, Zlowin.
  - F1: Zlowout, PCin, Read, MD_read, MDRin.
  - F2: MDRout, IRin.
  - Then T3. Decode IR[31:27] from T3 onward, when IR is valid.
- Execute sequences. The last state listed returns to F0.
  - ld 00000: T3 Grb, BAout, Yin. T4 Csignout, ADD, Zlowin. T5 Zlowout, MARin. T6 Read, MD_read, MDRin. T7 MDRout, Gra, Rin. Total 8 cycles.
  - ldi 00001: T3 Grb, BAout, Yin. T4 Csignout, ADD, Zlowin. T5 Zlowout, Gra, Rin. Total 6 cycles.
  - st 00010: T3–T5 as ld, except T5 is Zlowout, MARin. T6 Gra, Rout, MDRin with MD_read=0. T7 Write. Total 8 cycles.
  - add/sub/and/or 00011/00100/00101/00110: T3 Grb, Rout, Yin. T4 Grc, Rout, alu_op per opcode, Zlowin. T5 Zlowout, Gra, Rin. Total 6 cycles.
  - addi 01100: T3 Grb, Rout, Yin. T4 Csignout, ADD, Zlowin. T5 Zlowout, Gra, Rin. Total 6 cycles.
  - br 10010: T3 Gra, Rout, CONin. T4 PCout, Yin. T5 Csignout, ADD, Zlowin. T6 Zlowout, with PCin=CON_FF sampled in T6. Total 7 cycles.
  - jr 10100: T3 Gra, Rout, PCin. Total 4 cycles.
  - mfhi 10111: T3 HIout, Gra, Rin. mflo 11000: T3 LOout, Gra, Rin. Total 4 cycles each.
  - nop 11010 and any undefined opcode: T3 with no outputs, then F0. Total 4 cycles.
  - halt 11011: go to HALT.
- HALT: all outputs 0, Run=0. Exits only via clear.
- Stop handling:
  - Stop is latched into stop_pend on any edge where it is high.
  - When the last state of an instruction would transition to F0 with stop_pend=1, go to HALT instead.
  - Stop arriving in F0 still lets the current instruction complete.
- clear mid-instruction: immediate return to RESET with all outputs 0. stop_pend is cleared. No partial Write pulse may extend past clear.

Test Plan:
- Reset then ldi with IR=0x08800065 (ldi R1,0x65(R0)): F0–F2 then T3–T5 strobes exactly as listed; Rin+Gra in cycle 6; back in F0 at cycle 7.
- ld with IR=0x01000055: Read+MD_read+MDRin high only in F1 and T6; Gra+Rin+MDRout in T7; 8 cycles total.
- st: Write high for exactly one cycle (T7); MD_read=0 in T6; Read never high during T3–T7.
- br with CON_FF=0, then br with CON_FF=1: PCin in T6 is 0, then 1; CONin high only in T3.
- sub then undefined opcode 11111: alu_op=0001 in T4 only; undefined executes as a 4-cycle nop.
- Stop pulsed during T4 of add: add completes through T5, then HALT with Run=0. clear asserted mid-ld: outputs go to 0 immediately; restart at F0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini-CPU DataPath: fetch (F0-F2) then
// opcode-specific execute steps (T3-T7), with halt/stop handling.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     IR,
  input  logic            CON_FF,
  input  logic            Stop,
  output logic [9:0]      drv_out,
  output logic [11:0]     ld_in,
  output logic [2:0]      gr_sel,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            MD_read,
  output logic [ALUW-1:0] alu_op,
  output logic            Run
);

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_BR   = OPW'(18);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(23);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(24);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  // Bus driver bit positions
  localparam int D_PC = 0, D_ZLO = 1, D_MDR = 3, D_HI = 4, D_LO = 5;
  localparam int D_CSIGN = 7, D_R = 8, D_BA = 9;
  // Register load bit positions
  localparam int L_PC = 0, L_MAR = 1, L_MDR = 2, L_IR = 3, L_Y = 4;
  localparam int L_ZLO = 5, L_CON = 10, L_R = 11;
  // gr_sel = {Gra, Grb, Grc}
  localparam int G_A = 2, G_B = 1, G_C = 0;

  state_t         state;
  logic           stop_pend;
  logic           br_take;
  logic [OPW-1:0] opcode;
  logic           unused_ir;

  logic is_ld, is_ldi, is_st, is_alu, is_addi, is_br;
  logic is_jr, is_mfhi, is_mflo, is_halt, is_nop;
  logic is_last;
  state_t end_state;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  assign is_ld   = (opcode == OP_LD);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_st   = (opcode == OP_ST);
  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_addi = (opcode == OP_ADDI);
  assign is_br   = (opcode == OP_BR);
  assign is_jr   = (opcode == OP_JR);
  assign is_mfhi = (opcode == OP_MFHI);
  assign is_mflo = (opcode == OP_MFLO);
  assign is_halt = (opcode == OP_HALT);
  // nop and every undefined opcode share the single empty T3 step
  assign is_nop  = !(is_ld || is_ldi || is_st || is_alu || is_addi || is_br ||
                     is_jr || is_mfhi || is_mflo || is_halt);

  // A pending or coincident stop turns the instruction boundary into HALT
  assign end_state = (stop_pend || Stop) ? S_HALT : S_F0;

  always_comb begin
    is_last = 1'b0;
    case (state)
      S_T3:    is_last = is_jr || is_mfhi || is_mflo || is_nop;
      S_T5:    is_last = is_ldi || is_alu || is_addi;
      S_T6:    is_last = is_br;
      S_T7:    is_last = 1'b1;
      default: is_last = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= S_RESET;
      stop_pend <= 1'b0;
      br_take   <= 1'b0;
    end else begin
      if (Stop)
        stop_pend <= 1'b1;
      case (state)
        S_RESET: state <= S_F0;
        S_F0:    state <= S_F1;
        S_F1:    state <= S_F2;
        S_F2:    state <= S_T3;
        S_T3: begin
          if (is_halt)
            state <= S_HALT;
          else if (is_last)
            state <= end_state;
          else
            state <= S_T4;
        end
        S_T4:    state <= S_T5;
        S_T5: begin
          // CON_FF has been stable since the CONin load in T3
          br_take <= CON_FF;
          state   <= is_last ? end_state : S_T6;
        end
        S_T6:    state <= is_last ? end_state : S_T7;
        S_T7:    state <= end_state;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Moore output decode from the registered state and the IR opcode
  always_comb begin
    drv_out = '0;
    ld_in   = '0;
    gr_sel  = '0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    MD_read = 1'b0;
    alu_op  = '0;
    Run     = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_F0: begin
        drv_out[D_PC] = 1'b1;
        ld_in[L_MAR]  = 1'b1;
        ld_in[L_ZLO]  = 1'b1;
        IncPC         = 1'b1;
      end
      S_F1: begin
        drv_out[D_ZLO] = 1'b1;
        ld_in[L_PC]    = 1'b1;
        ld_in[L_MDR]   = 1'b1;
        Read           = 1'b1;
        MD_read        = 1'b1;
      end
      S_F2: begin
        drv_out[D_MDR] = 1'b1;
        ld_in[L_IR]    = 1'b1;
      end
      S_T3: begin
        if (is_ld || is_ldi || is_st) begin
          gr_sel[G_B]   = 1'b1;
          drv_out[D_BA] = 1'b1;
          ld_in[L_Y]    = 1'b1;
        end else if (is_alu || is_addi) begin
          gr_sel[G_B]  = 1'b1;
          drv_out[D_R] = 1'b1;
          ld_in[L_Y]   = 1'b1;
        end else if (is_br) begin
          gr_sel[G_A]  = 1'b1;
          drv_out[D_R] = 1'b1;
          ld_in[L_CON] = 1'b1;
        end else if (is_jr) begin
          gr_sel[G_A]  = 1'b1;
          drv_out[D_R] = 1'b1;
          ld_in[L_PC]  = 1'b1;
        end else if (is_mfhi || is_mflo) begin
          drv_out[D_HI] = is_mfhi;
          drv_out[D_LO] = is_mflo;
          gr_sel[G_A]   = 1'b1;
          ld_in[L_R]    = 1'b1;
        end
      end
      S_T4: begin
        if (is_ld || is_ldi || is_st || is_addi) begin
          drv_out[D_CSIGN] = 1'b1;
          ld_in[L_ZLO]     = 1'b1;
        end else if (is_alu) begin
          gr_sel[G_C]  = 1'b1;
          drv_out[D_R] = 1'b1;
          ld_in[L_ZLO] = 1'b1;
          case (opcode)
            OP_SUB:  alu_op = ALUW'(1);
            OP_AND:  alu_op = ALUW'(2);
            OP_OR:   alu_op = ALUW'(3);
            default: alu_op = ALUW'(0);
          endcase
        end else if (is_br) begin
          drv_out[D_PC] = 1'b1;
          ld_in[L_Y]    = 1'b1;
        end
      end
      S_T5: begin
        if (is_ld || is_st) begin
          drv_out[D_ZLO] = 1'b1;
          ld_in[L_MAR]   = 1'b1;
        end else if (is_ldi || is_alu || is_addi) begin
          drv_out[D_ZLO] = 1'b1;
          gr_sel[G_A]    = 1'b1;
          ld_in[L_R]     = 1'b1;
        end else if (is_br) begin
          drv_out[D_CSIGN] = 1'b1;
          ld_in[L_ZLO]     = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read         = 1'b1;
          MD_read      = 1'b1;
          ld_in[L_MDR] = 1'b1;
        end else if (is_st) begin
          gr_sel[G_A]  = 1'b1;
          drv_out[D_R] = 1'b1;
          ld_in[L_MDR] = 1'b1;
        end else if (is_br) begin
          drv_out[D_ZLO] = 1'b1;
          ld_in[L_PC]    = br_take;
        end
      end
      S_T7: begin
        if (is_ld) begin
          drv_out[D_MDR] = 1'b1;
          gr_sel[G_A]    = 1'b1;
          ld_in[L_R]     = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
